// File: rtl/hack_pkg.sv
// Shared widths and instruction bit positions for the Hack CPU slice.
package hack_pkg;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 15;

  localparam int unsigned I_TYPE = 15;
  localparam int unsigned I_A    = 12;
  localparam int unsigned I_ZX   = 11;
  localparam int unsigned I_NX   = 10;
  localparam int unsigned I_ZY   = 9;
  localparam int unsigned I_NY   = 8;
  localparam int unsigned I_F    = 7;
  localparam int unsigned I_NO   = 6;
  localparam int unsigned I_D1   = 5;
  localparam int unsigned I_D2   = 4;
  localparam int unsigned I_D3   = 3;
  localparam int unsigned I_J1   = 2;
  localparam int unsigned I_J2   = 1;
  localparam int unsigned I_J3   = 0;
endpackage

// File: rtl/hack_cpu_alu.sv
// 16-bit Hack ALU: optional zero/negate on each operand, add or and, optional negate of result.
module ALU
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [WORD_W-1:0] out,
  output logic              zr,
  output logic              ng
);
  logic [WORD_W-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    // Carry out of the add is discarded; the sum wraps at 16 bits.
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
    zr  = (out == '0);
    ng  = out[WORD_W-1];
  end
endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: decodes A/C instructions, drives the ALU, holds A, D and PC, resolves jumps.
module hack_cpu
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [WORD_W-1:0] instruction,
  input  logic [WORD_W-1:0] inM,
  output logic [WORD_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);
  logic [WORD_W-1:0] a_reg, d_reg, alu_y, alu_out;
  logic [ADDR_W-1:0] pc_reg;
  logic              is_c, alu_zr, alu_ng, jump;

  assign is_c  = instruction[I_TYPE];
  assign alu_y = instruction[I_A] ? inM : a_reg;

  ALU u_alu (
    .x  (d_reg),
    .y  (alu_y),
    .zx (instruction[I_ZX]),
    .nx (instruction[I_NX]),
    .zy (instruction[I_ZY]),
    .ny (instruction[I_NY]),
    .f  (instruction[I_F]),
    .no (instruction[I_NO]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  assign jump = is_c & ((instruction[I_J1] & alu_ng) |
                        (instruction[I_J2] & alu_zr) |
                        (instruction[I_J3] & ~alu_ng & ~alu_zr));

  assign outM     = alu_out;
  assign writeM   = is_c & instruction[I_D3] & ~stall & ~reset;
  assign addressM = a_reg[ADDR_W-1:0];
  assign pc       = pc_reg;

  // Jump target and memory address both use A as it was before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= '0;
    end else if (!stall) begin
      if (!is_c)
        a_reg <= instruction;
      else if (instruction[I_D1])
        a_reg <= alu_out;
      if (is_c && instruction[I_D2])
        d_reg <= alu_out;
      pc_reg <= jump ? a_reg[ADDR_W-1:0] : pc_reg + 15'd1;
    end
  end
endmodule
